// File: rtl/sb_mac16_pkg.sv
// Shared encodings and multiplier helpers for the sb_mac16 DSP slice model.
package sb_mac16_pkg;

  // Output half source select
  localparam logic [1:0] OSEL_ADDER = 2'd0;
  localparam logic [1:0] OSEL_ACCUM = 2'd1;
  localparam logic [1:0] OSEL_MUL8  = 2'd2;
  localparam logic [1:0] OSEL_MUL16 = 2'd3;

  // Adder upper operand select
  localparam logic UPPER_ACCUM = 1'b0;
  localparam logic UPPER_CD    = 1'b1;

  // Adder lower operand select
  localparam logic [1:0] LOWER_AB    = 2'd0;
  localparam logic [1:0] LOWER_MUL8  = 2'd1;
  localparam logic [1:0] LOWER_MUL16 = 2'd2;
  localparam logic [1:0] LOWER_SEXT  = 2'd3;

  // Carry-in select; on the top adder both 2 and 3 take the bottom carry-out
  localparam logic [1:0] CSEL_ZERO    = 2'd0;
  localparam logic [1:0] CSEL_ONE     = 2'd1;
  localparam logic [1:0] CSEL_ACCUMCI = 2'd2;
  localparam logic [1:0] CSEL_CI      = 2'd3;

  localparam int NUM_OPS      = 4;
  localparam int NUM_PARTIALS = 4;

  function automatic logic [31:0] ext8(input logic [7:0] v, input logic is_signed);
    ext8 = is_signed ? {{24{v[7]}}, v} : {24'd0, v};
  endfunction

  // Low 32 bits of the product of two extended bytes are exact for either signedness.
  function automatic logic [31:0] mul8x8(input logic [7:0] a, input logic [7:0] b,
                                         input logic a_signed, input logic b_signed);
    mul8x8 = ext8(a, a_signed) * ext8(b, b_signed);
  endfunction

endpackage

// File: rtl/sb_mac16_addsub16.sv
// One 16-bit add/subtract unit with carry chain and its accumulator register.
module mac16_addsub16
  import sb_mac16_pkg::*;
#(
  parameter logic UPPER_INPUT = UPPER_ACCUM
) (
  input  logic        clk,
  input  logic        srst,
  input  logic        ce,
  input  logic        hold,
  input  logic        load,
  input  logic        sub,
  input  logic [15:0] cd,
  input  logic [15:0] x,
  input  logic        ci,
  output logic [15:0] z,
  output logic [15:0] q,
  output logic        cout
);

  logic [15:0] q_reg;
  logic [15:0] q_next;
  logic [15:0] u;
  logic [16:0] sum;

  assign u = (UPPER_INPUT == UPPER_CD) ? cd : q_reg;

  // In subtract mode bit 16 of the wrapped difference is the borrow.
  always_comb begin
    if (sub) begin
      sum = {1'b0, u} - {1'b0, x} - {16'd0, ci};
    end else begin
      sum = {1'b0, u} + {1'b0, x} + {16'd0, ci};
    end
  end

  assign z    = sum[15:0];
  assign cout = sum[16];

  always_comb begin
    q_next = q_reg;
    if (ce && !hold) begin
      q_next = load ? cd : sum[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      q_reg <= '0;
    end else begin
      q_reg <= q_next;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/sb_mac16.sv
// iCE40 SB_MAC16 behavioural model: operand registers, 8x8/16x16 multipliers,
// two cascaded add/sub/accumulate halves, 32-bit output.
module sb_mac16
  import sb_mac16_pkg::*;
#(
  parameter logic       A_REG                    = 1'b0,
  parameter logic       B_REG                    = 1'b0,
  parameter logic       C_REG                    = 1'b0,
  parameter logic       D_REG                    = 1'b0,
  parameter logic       TOP_8x8_MULT_REG         = 1'b0,
  parameter logic       BOT_8x8_MULT_REG         = 1'b0,
  parameter logic       PIPELINE_16x16_MULT_REG1 = 1'b0,
  parameter logic       PIPELINE_16x16_MULT_REG2 = 1'b0,
  parameter logic [1:0] TOPOUTPUT_SELECT         = 2'd0,
  parameter logic [1:0] BOTOUTPUT_SELECT         = 2'd0,
  parameter logic       TOPADDSUB_UPPERINPUT     = 1'b0,
  parameter logic       BOTADDSUB_UPPERINPUT     = 1'b0,
  parameter logic [1:0] TOPADDSUB_LOWERINPUT     = 2'd0,
  parameter logic [1:0] BOTADDSUB_LOWERINPUT     = 2'd0,
  parameter logic [1:0] TOPADDSUB_CARRYSELECT    = 2'd0,
  parameter logic [1:0] BOTADDSUB_CARRYSELECT    = 2'd0,
  parameter logic       MODE_8x8                 = 1'b0,
  parameter logic       A_SIGNED                 = 1'b0,
  parameter logic       B_SIGNED                 = 1'b0
) (
  input  logic        CLK,
  input  logic        IRSTTOP,
  input  logic        IRSTBOT,
  input  logic        ORSTTOP,
  input  logic        ORSTBOT,
  input  logic        CE,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic [15:0] C,
  input  logic [15:0] D,
  input  logic        AHOLD,
  input  logic        BHOLD,
  input  logic        CHOLD,
  input  logic        DHOLD,
  input  logic        OHOLDTOP,
  input  logic        OHOLDBOT,
  input  logic        OLOADTOP,
  input  logic        OLOADBOT,
  input  logic        ADDSUBTOP,
  input  logic        ADDSUBBOT,
  input  logic        CI,
  input  logic        ACCUMCI,
  input  logic        SIGNEXTIN,
  output logic [31:0] O,
  output logic        CO,
  output logic        ACCUMCO,
  output logic        SIGNEXTOUT
);

  genvar gi;

  // Operand index order: 0=A, 1=B, 2=C, 3=D
  localparam logic [NUM_OPS-1:0] OP_REG = {D_REG, C_REG, B_REG, A_REG};

  logic [15:0]        op_raw [NUM_OPS];
  logic [15:0]        op_eff [NUM_OPS];
  logic [NUM_OPS-1:0] op_hold;
  logic [NUM_OPS-1:0] op_rst;

  assign op_raw[0] = A;
  assign op_raw[1] = B;
  assign op_raw[2] = C;
  assign op_raw[3] = D;
  assign op_hold   = {DHOLD, CHOLD, BHOLD, AHOLD};
  assign op_rst    = {IRSTBOT, IRSTTOP, IRSTBOT, IRSTTOP};

  generate
    for (gi = 0; gi < NUM_OPS; gi++) begin : g_op
      logic [15:0] op_reg;

      always_ff @(posedge CLK) begin
        if (op_rst[gi]) begin
          op_reg <= '0;
        end else if (CE && !op_hold[gi]) begin
          op_reg <= op_raw[gi];
        end
      end

      assign op_eff[gi] = OP_REG[gi] ? op_reg : op_raw[gi];
    end
  endgenerate

  // Partial index {a_hi, b_hi}: 3=hi*hi (F), 2=hi*lo, 1=lo*hi, 0=lo*lo (G).
  // Only high bytes carry the operand sign, so lo*lo is always unsigned.
  logic [31:0] pp_comb [NUM_PARTIALS];
  logic [31:0] pp_eff  [NUM_PARTIALS];

  generate
    for (gi = 0; gi < NUM_PARTIALS; gi++) begin : g_pp
      localparam logic A_HI = (gi >= 2);
      localparam logic B_HI = ((gi % 2) == 1);

      logic [7:0]  a_byte;
      logic [7:0]  b_byte;
      logic [31:0] pp_reg;

      assign a_byte      = A_HI ? op_eff[0][15:8] : op_eff[0][7:0];
      assign b_byte      = B_HI ? op_eff[1][15:8] : op_eff[1][7:0];
      assign pp_comb[gi] = mul8x8(a_byte, b_byte, A_HI && A_SIGNED, B_HI && B_SIGNED);

      always_ff @(posedge CLK) begin
        if (IRSTTOP) begin
          pp_reg <= '0;
        end else if (CE) begin
          pp_reg <= pp_comb[gi];
        end
      end

      assign pp_eff[gi] = PIPELINE_16x16_MULT_REG1 ? pp_reg : pp_comb[gi];
    end
  endgenerate

  logic [15:0] f_reg;
  logic [15:0] g_reg;
  logic [31:0] h_reg;
  logic [15:0] f_eff;
  logic [15:0] g_eff;
  logic [31:0] h_comb;
  logic [31:0] h_eff;

  assign h_comb = (pp_eff[3] << 16) + (pp_eff[2] << 8) + (pp_eff[1] << 8) + pp_eff[0];

  always_ff @(posedge CLK) begin
    if (IRSTTOP) begin
      f_reg <= '0;
    end else if (CE) begin
      f_reg <= pp_comb[3][15:0];
    end
  end

  always_ff @(posedge CLK) begin
    if (IRSTBOT) begin
      g_reg <= '0;
      h_reg <= '0;
    end else if (CE) begin
      g_reg <= pp_comb[0][15:0];
      h_reg <= h_comb;
    end
  end

  assign f_eff = TOP_8x8_MULT_REG ? f_reg : pp_comb[3][15:0];
  assign g_eff = BOT_8x8_MULT_REG ? g_reg : pp_comb[0][15:0];
  assign h_eff = MODE_8x8 ? 32'd0 : (PIPELINE_16x16_MULT_REG2 ? h_reg : h_comb);

  logic [15:0] x_bot;
  logic [15:0] x_top;
  logic        ci_bot;
  logic        ci_top;
  logic [15:0] z_bot;
  logic [15:0] z_top;
  logic [15:0] q_bot;
  logic [15:0] q_top;
  logic        cout_bot;
  logic        cout_top;

  always_comb begin
    x_bot = op_eff[1];
    case (BOTADDSUB_LOWERINPUT)
      LOWER_AB:    x_bot = op_eff[1];
      LOWER_MUL8:  x_bot = g_eff;
      LOWER_MUL16: x_bot = h_eff[15:0];
      LOWER_SEXT:  x_bot = {16{SIGNEXTIN}};
      default:     x_bot = op_eff[1];
    endcase
  end

  always_comb begin
    x_top = op_eff[0];
    case (TOPADDSUB_LOWERINPUT)
      LOWER_AB:    x_top = op_eff[0];
      LOWER_MUL8:  x_top = f_eff;
      LOWER_MUL16: x_top = h_eff[31:16];
      LOWER_SEXT:  x_top = {16{x_bot[15]}};
      default:     x_top = op_eff[0];
    endcase
  end

  always_comb begin
    ci_bot = 1'b0;
    case (BOTADDSUB_CARRYSELECT)
      CSEL_ZERO:    ci_bot = 1'b0;
      CSEL_ONE:     ci_bot = 1'b1;
      CSEL_ACCUMCI: ci_bot = ACCUMCI;
      CSEL_CI:      ci_bot = CI;
      default:      ci_bot = 1'b0;
    endcase
  end

  always_comb begin
    ci_top = 1'b0;
    case (TOPADDSUB_CARRYSELECT)
      CSEL_ZERO: ci_top = 1'b0;
      CSEL_ONE:  ci_top = 1'b1;
      default:   ci_top = cout_bot;
    endcase
  end

  mac16_addsub16 #(
    .UPPER_INPUT(BOTADDSUB_UPPERINPUT)
  ) u_bot (
    .clk  (CLK),
    .srst (ORSTBOT),
    .ce   (CE),
    .hold (OHOLDBOT),
    .load (OLOADBOT),
    .sub  (ADDSUBBOT),
    .cd   (op_eff[3]),
    .x    (x_bot),
    .ci   (ci_bot),
    .z    (z_bot),
    .q    (q_bot),
    .cout (cout_bot)
  );

  mac16_addsub16 #(
    .UPPER_INPUT(TOPADDSUB_UPPERINPUT)
  ) u_top (
    .clk  (CLK),
    .srst (ORSTTOP),
    .ce   (CE),
    .hold (OHOLDTOP),
    .load (OLOADTOP),
    .sub  (ADDSUBTOP),
    .cd   (op_eff[2]),
    .x    (x_top),
    .ci   (ci_top),
    .z    (z_top),
    .q    (q_top),
    .cout (cout_top)
  );

  logic [15:0] o_top;
  logic [15:0] o_bot;

  always_comb begin
    o_top = z_top;
    case (TOPOUTPUT_SELECT)
      OSEL_ADDER: o_top = z_top;
      OSEL_ACCUM: o_top = q_top;
      OSEL_MUL8:  o_top = f_eff;
      OSEL_MUL16: o_top = h_eff[31:16];
      default:    o_top = z_top;
    endcase
  end

  always_comb begin
    o_bot = z_bot;
    case (BOTOUTPUT_SELECT)
      OSEL_ADDER: o_bot = z_bot;
      OSEL_ACCUM: o_bot = q_bot;
      OSEL_MUL8:  o_bot = g_eff;
      OSEL_MUL16: o_bot = h_eff[15:0];
      default:    o_bot = z_bot;
    endcase
  end

  assign O          = {o_top, o_bot};
  assign CO         = cout_top;
  assign ACCUMCO    = cout_top;
  assign SIGNEXTOUT = x_top[15];

endmodule

// File: tb/tb_sb_mac16.sv
// Self-checking bench for sb_mac16: combinational vector table plus sequential sequences.
module tb_sb_mac16;

  logic        CLK = 1'b0;
  logic        IRSTTOP, IRSTBOT, ORSTTOP, ORSTBOT, CE;
  logic [15:0] A, B, C, D;
  logic        AHOLD, BHOLD, CHOLD, DHOLD;
  logic        OHOLDTOP, OHOLDBOT, OLOADTOP, OLOADBOT;
  logic        ADDSUBTOP, ADDSUBBOT, CI, ACCUMCI, SIGNEXTIN;

  // Instance index: 0 subtractor, 1 signed 16x16, 2 MODE_8x8, 3 accumulator, 4 registered inputs
  logic [31:0] o   [5];
  logic        co  [5];
  logic        aco [5];
  logic        seo [5];

  always #5 CLK = ~CLK;

  sb_mac16 #(
    .TOPOUTPUT_SELECT(2'd0), .BOTOUTPUT_SELECT(2'd0),
    .TOPADDSUB_UPPERINPUT(1'b1), .BOTADDSUB_UPPERINPUT(1'b1),
    .TOPADDSUB_LOWERINPUT(2'd0), .BOTADDSUB_LOWERINPUT(2'd0),
    .TOPADDSUB_CARRYSELECT(2'd2), .BOTADDSUB_CARRYSELECT(2'd0)
  ) u_sub (
    .CLK(CLK), .IRSTTOP(IRSTTOP), .IRSTBOT(IRSTBOT), .ORSTTOP(ORSTTOP), .ORSTBOT(ORSTBOT), .CE(CE),
    .A(A), .B(B), .C(C), .D(D), .AHOLD(AHOLD), .BHOLD(BHOLD), .CHOLD(CHOLD), .DHOLD(DHOLD),
    .OHOLDTOP(OHOLDTOP), .OHOLDBOT(OHOLDBOT), .OLOADTOP(OLOADTOP), .OLOADBOT(OLOADBOT),
    .ADDSUBTOP(ADDSUBTOP), .ADDSUBBOT(ADDSUBBOT), .CI(CI), .ACCUMCI(ACCUMCI), .SIGNEXTIN(SIGNEXTIN),
    .O(o[0]), .CO(co[0]), .ACCUMCO(aco[0]), .SIGNEXTOUT(seo[0])
  );

  sb_mac16 #(
    .TOPOUTPUT_SELECT(2'd3), .BOTOUTPUT_SELECT(2'd3), .A_SIGNED(1'b1), .B_SIGNED(1'b1)
  ) u_mul (
    .CLK(CLK), .IRSTTOP(IRSTTOP), .IRSTBOT(IRSTBOT), .ORSTTOP(ORSTTOP), .ORSTBOT(ORSTBOT), .CE(CE),
    .A(A), .B(B), .C(C), .D(D), .AHOLD(AHOLD), .BHOLD(BHOLD), .CHOLD(CHOLD), .DHOLD(DHOLD),
    .OHOLDTOP(OHOLDTOP), .OHOLDBOT(OHOLDBOT), .OLOADTOP(OLOADTOP), .OLOADBOT(OLOADBOT),
    .ADDSUBTOP(ADDSUBTOP), .ADDSUBBOT(ADDSUBBOT), .CI(CI), .ACCUMCI(ACCUMCI), .SIGNEXTIN(SIGNEXTIN),
    .O(o[1]), .CO(co[1]), .ACCUMCO(aco[1]), .SIGNEXTOUT(seo[1])
  );

  sb_mac16 #(
    .TOPOUTPUT_SELECT(2'd3), .BOTOUTPUT_SELECT(2'd3), .A_SIGNED(1'b1), .B_SIGNED(1'b1),
    .MODE_8x8(1'b1)
  ) u_m8 (
    .CLK(CLK), .IRSTTOP(IRSTTOP), .IRSTBOT(IRSTBOT), .ORSTTOP(ORSTTOP), .ORSTBOT(ORSTBOT), .CE(CE),
    .A(A), .B(B), .C(C), .D(D), .AHOLD(AHOLD), .BHOLD(BHOLD), .CHOLD(CHOLD), .DHOLD(DHOLD),
    .OHOLDTOP(OHOLDTOP), .OHOLDBOT(OHOLDBOT), .OLOADTOP(OLOADTOP), .OLOADBOT(OLOADBOT),
    .ADDSUBTOP(ADDSUBTOP), .ADDSUBBOT(ADDSUBBOT), .CI(CI), .ACCUMCI(ACCUMCI), .SIGNEXTIN(SIGNEXTIN),
    .O(o[2]), .CO(co[2]), .ACCUMCO(aco[2]), .SIGNEXTOUT(seo[2])
  );

  sb_mac16 #(
    .TOPOUTPUT_SELECT(2'd1), .BOTOUTPUT_SELECT(2'd1),
    .TOPADDSUB_UPPERINPUT(1'b0), .BOTADDSUB_UPPERINPUT(1'b0),
    .TOPADDSUB_LOWERINPUT(2'd0), .BOTADDSUB_LOWERINPUT(2'd0),
    .TOPADDSUB_CARRYSELECT(2'd0), .BOTADDSUB_CARRYSELECT(2'd0)
  ) u_acc (
    .CLK(CLK), .IRSTTOP(IRSTTOP), .IRSTBOT(IRSTBOT), .ORSTTOP(ORSTTOP), .ORSTBOT(ORSTBOT), .CE(CE),
    .A(A), .B(B), .C(C), .D(D), .AHOLD(AHOLD), .BHOLD(BHOLD), .CHOLD(CHOLD), .DHOLD(DHOLD),
    .OHOLDTOP(OHOLDTOP), .OHOLDBOT(OHOLDBOT), .OLOADTOP(OLOADTOP), .OLOADBOT(OLOADBOT),
    .ADDSUBTOP(ADDSUBTOP), .ADDSUBBOT(ADDSUBBOT), .CI(CI), .ACCUMCI(ACCUMCI), .SIGNEXTIN(SIGNEXTIN),
    .O(o[3]), .CO(co[3]), .ACCUMCO(aco[3]), .SIGNEXTOUT(seo[3])
  );

  sb_mac16 #(
    .A_REG(1'b1), .B_REG(1'b1),
    .TOPOUTPUT_SELECT(2'd3), .BOTOUTPUT_SELECT(2'd3), .A_SIGNED(1'b1), .B_SIGNED(1'b1)
  ) u_reg (
    .CLK(CLK), .IRSTTOP(IRSTTOP), .IRSTBOT(IRSTBOT), .ORSTTOP(ORSTTOP), .ORSTBOT(ORSTBOT), .CE(CE),
    .A(A), .B(B), .C(C), .D(D), .AHOLD(AHOLD), .BHOLD(BHOLD), .CHOLD(CHOLD), .DHOLD(DHOLD),
    .OHOLDTOP(OHOLDTOP), .OHOLDBOT(OHOLDBOT), .OLOADTOP(OLOADTOP), .OLOADBOT(OLOADBOT),
    .ADDSUBTOP(ADDSUBTOP), .ADDSUBBOT(ADDSUBBOT), .CI(CI), .ACCUMCI(ACCUMCI), .SIGNEXTIN(SIGNEXTIN),
    .O(o[4]), .CO(co[4]), .ACCUMCO(aco[4]), .SIGNEXTOUT(seo[4])
  );

  typedef struct {
    logic [15:0] a, b, c, d;
    logic        sub;
    logic [31:0] exp_o;
    logic        exp_co;
    logic [31:0] exp_mul;
  } vec_t;

  vec_t        vecs [8];
  logic [31:0] exp_q [$];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act);
    logic [31:0] e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: got %h, scoreboard empty", name, act);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", name, act, e);
      end else begin
        $display("ok   %s: %h", name, act);
      end
    end
  endtask

  initial begin
    logic [31:0] cd, ab;
    logic [32:0] ref_sum;

    //             a         b         c         d         sub   exp_o          co    exp_mul
    vecs[0] = '{16'h0000, 16'h1000, 16'h0000, 16'h0123, 1'b1, 32'hFFFFF123, 1'b1, 32'h00000000};
    vecs[1] = '{16'h0000, 16'h1000, 16'h0000, 16'h1123, 1'b1, 32'h00000123, 1'b0, 32'h00000000};
    vecs[2] = '{16'h0000, 16'h0001, 16'h0000, 16'hFFFF, 1'b0, 32'h00010000, 1'b0, 32'h00000000};
    vecs[3] = '{16'hFFFE, 16'h0003, 16'h0000, 16'h0000, 1'b1, 32'h0001FFFD, 1'b1, 32'hFFFFFFFA};
    vecs[4] = '{16'h7FFF, 16'h7FFF, 16'h0000, 16'h0000, 1'b1, 32'h80008001, 1'b1, 32'h3FFF0001};
    vecs[5] = '{16'h8000, 16'h8000, 16'h1234, 16'h5678, 1'b1, 32'h9233D678, 1'b1, 32'h40000000};
    vecs[6] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1, 32'h00000000, 1'b0, 32'h00000001};
    vecs[7] = '{16'h0102, 16'h0304, 16'h0000, 16'h0000, 1'b1, 32'hFEFDFCFC, 1'b1, 32'h00030A08};

    {A, B, C, D} = '0;
    {AHOLD, BHOLD, CHOLD, DHOLD, OHOLDTOP, OHOLDBOT, OLOADTOP, OLOADBOT} = '0;
    {ADDSUBTOP, ADDSUBBOT, CI, ACCUMCI, SIGNEXTIN} = '0;
    {IRSTTOP, IRSTBOT, ORSTTOP, ORSTBOT} = 4'hF;
    CE = 1'b1;

    // Reset state
    tick();
    tick();
    push(32'd0); check("reset acc O", o[3]);
    push(32'd0); check("reset reg O", o[4]);
    {IRSTTOP, IRSTBOT, ORSTTOP, ORSTBOT} = 4'h0;

    // Combinational vectors
    for (int i = 0; i < 8; i++) begin
      A = vecs[i].a; B = vecs[i].b; C = vecs[i].c; D = vecs[i].d;
      ADDSUBTOP = vecs[i].sub; ADDSUBBOT = vecs[i].sub;
      push(vecs[i].exp_o);
      push({30'd0, vecs[i].exp_co, vecs[i].exp_co});
      push(vecs[i].exp_mul);
      push(32'd0);
      #1;
      check($sformatf("vec%0d sub O", i), o[0]);
      check($sformatf("vec%0d CO/ACCUMCO", i), {30'd0, co[0], aco[0]});
      check($sformatf("vec%0d mul16 O", i), o[1]);
      check($sformatf("vec%0d mode8x8 O", i), o[2]);
    end

    // Random add/sub against a 33-bit reference
    for (int i = 0; i < 8; i++) begin
      A = 16'($urandom); B = 16'($urandom); C = 16'($urandom); D = 16'($urandom);
      ADDSUBTOP = i[0]; ADDSUBBOT = i[0];
      cd = {C, D}; ab = {A, B};
      ref_sum = i[0] ? ({1'b0, cd} - {1'b0, ab}) : ({1'b0, cd} + {1'b0, ab});
      push(ref_sum[31:0]);
      push({31'd0, ref_sum[32]});
      #1;
      check($sformatf("rnd%0d sub O", i), o[0]);
      check($sformatf("rnd%0d CO", i), {31'd0, co[0]});
    end

    // Accumulator sequences
    ORSTTOP = 1'b1; ORSTBOT = 1'b1;
    ADDSUBTOP = 1'b0; ADDSUBBOT = 1'b0;
    A = 16'd0; B = 16'd5; C = 16'd0; D = 16'd0;
    tick();
    ORSTTOP = 1'b0; ORSTBOT = 1'b0;
    push(32'd0); check("acc after reset", o[3]);
    repeat (3) tick();
    push(32'h0000000F); check("acc 3 edges", o[3]);
    OHOLDBOT = 1'b1;
    repeat (2) tick();
    push(32'h0000000F); check("acc hold", o[3]);
    OHOLDBOT = 1'b0; ORSTBOT = 1'b1;
    tick();
    ORSTBOT = 1'b0; B = 16'd0;
    push(32'd0); check("acc orst", o[3]);
    OLOADTOP = 1'b1; C = 16'h1234;
    tick();
    OLOADTOP = 1'b0;
    push(32'h12340000); check("acc load", o[3]);
    A = 16'd1; CE = 1'b0;
    tick();
    push(32'h12340000); check("acc ce0", o[3]);
    CE = 1'b1;
    tick();
    A = 16'd0;
    push(32'h12350000); check("acc ce1", o[3]);
    OLOADTOP = 1'b1; ORSTTOP = 1'b1;
    tick();
    OLOADTOP = 1'b0; ORSTTOP = 1'b0;
    push(32'd0); check("load vs reset", o[3]);

    // Registered-input multiplier
    A = 16'd3; B = 16'd4;
    tick();
    push(32'd12); check("reg first", o[4]);
    A = 16'd5; B = 16'd6;
    #1;
    push(32'd12); check("reg latency", o[4]);
    tick();
    push(32'd30); check("reg second", o[4]);
    AHOLD = 1'b1; A = 16'd7; B = 16'd2;
    tick();
    push(32'd10); check("reg ahold", o[4]);
    AHOLD = 1'b0; CE = 1'b0; A = 16'd9; B = 16'd9;
    tick();
    push(32'd10); check("reg ce0", o[4]);
    CE = 1'b1;
    tick();
    push(32'd81); check("reg ce1", o[4]);
    A = 16'hFFFF; B = 16'd2;
    tick();
    push(32'hFFFFFFFE); check("reg signed", o[4]);
    IRSTTOP = 1'b1;
    tick();
    IRSTTOP = 1'b0;
    push(32'd0); check("reg irst", o[4]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
